mul_rr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one sequential_multiplier_top (Booth, valid/ready) instance among NUM_REQ requesters.
- Accepts one operand pair at a time from the winning requester and drives it into the multiplier's src handshake.
- Collects the product via the multiplier's dest handshake and returns it to the originating requester only.
- Sits between client blocks and the multiplier; it owns the multiplier's src/dest handshake pins exclusively.

---
 rtl/mul_rr_arbiter.sv | 117 +++++++++++
 tb/tb_mul_rr_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_rr_arbiter.sv
// mul_rr_arbiter
//   Round-robin front end that shares one sequential multiplier among
//   NUM_REQ requesters. Exactly one job is in flight at a time. A job moves
//   through four states: IDLE (arbitrate and accept), ISSUE (src handshake),
//   WAIT (dest handshake) and RESP (return the product to its owner).
//
// Ports
//   clk, rst                 clock; synchronous active-low reset
//   req_valid/req_ready      per-requester operand handshake (ready one-hot)
//   req_multiplicand/_mult.  packed operands, slice i = requester i
//   rsp_valid/rsp_ready      per-requester result handshake (valid one-hot)
//   rsp_product              shared signed result bus
//   mul_*                    exclusive connection to the multiplier
//   busy, grant_id           status: not-idle flag and current owner index
module mul_rr_arbiter #(
  parameter int MUL_WIDTH = 16,
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*MUL_WIDTH-1:0] req_multiplicand,
  input  logic [NUM_REQ*MUL_WIDTH-1:0] req_multiplier,
  output logic [NUM_REQ-1:0]           rsp_valid,
  input  logic [NUM_REQ-1:0]           rsp_ready,
  output logic [2*MUL_WIDTH-1:0]       rsp_product,
  output logic [MUL_WIDTH-1:0]         mul_multiplicand,
  output logic [MUL_WIDTH-1:0]         mul_multiplier,
  output logic                         mul_src_valid,
  input  logic                         mul_src_ready,
  input  logic                         mul_dest_valid,
  output logic                         mul_dest_ready,
  input  logic [2*MUL_WIDTH-1:0]       mul_product,
  output logic                         busy,
  output logic [ID_W-1:0]              grant_id
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [ID_W-1:0] last;
  logic [ID_W-1:0] winner;
  logic            found;

  // Search from last+1 upward with wrap; the first valid requester wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      int unsigned     idx;
      logic [ID_W-1:0] cand;
      idx  = (32'(last) + off) % NUM_REQ;
      cand = idx[ID_W-1:0];
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (found)                state_next = ISSUE;
      ISSUE:   if (mul_src_ready)        state_next = WAIT;
      WAIT:    if (mul_dest_valid)       state_next = RESP;
      RESP:    if (rsp_ready[grant_id])  state_next = IDLE;
      default:                           state_next = IDLE;
    endcase
  end

  // Combinational handshake outputs are gated by rst so that every output
  // reads 0 while reset is held, even though requests may be pending.
  always_comb begin
    req_ready      = '0;
    rsp_valid      = '0;
    mul_dest_ready = 1'b0;
    if (rst) begin
      if (state == IDLE && found) req_ready[winner] = 1'b1;
      if (state == RESP)          rsp_valid[grant_id] = 1'b1;
      mul_dest_ready = (state == WAIT) && mul_dest_valid;
    end
  end

  // state is a register, so this is a registered valid.
  assign mul_src_valid = (state == ISSUE);
  assign busy          = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= IDLE;
      last             <= ID_W'(NUM_REQ - 1);
      grant_id         <= '0;
      mul_multiplicand <= '0;
      mul_multiplier   <= '0;
      rsp_product      <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && found) begin
        grant_id         <= winner;
        mul_multiplicand <= req_multiplicand[winner*MUL_WIDTH +: MUL_WIDTH];
        mul_multiplier   <= req_multiplier[winner*MUL_WIDTH +: MUL_WIDTH];
      end
      if (state == WAIT && mul_dest_valid) rsp_product <= mul_product;
      if (state == RESP && rsp_ready[grant_id]) last <= grant_id;
    end
  end

endmodule

// File: tb/tb_mul_rr_arbiter.sv
// tb_mul_rr_arbiter
//   Directed bench for mul_rr_arbiter. A simple multiplier stand-in is
//   driven from the job task; products are checked against hand values.
module tb_mul_rr_arbiter;

  localparam int W = 16;
  localparam int N = 4;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*W-1:0]  req_multiplicand;
  logic [N*W-1:0]  req_multiplier;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready;
  logic [2*W-1:0]  rsp_product;
  logic [W-1:0]    mul_multiplicand;
  logic [W-1:0]    mul_multiplier;
  logic            mul_src_valid;
  logic            mul_src_ready;
  logic            mul_dest_valid;
  logic            mul_dest_ready;
  logic [2*W-1:0]  mul_product;
  logic            busy;
  logic [1:0]      grant_id;

  int checks = 0;
  int errors = 0;

  mul_rr_arbiter #(.MUL_WIDTH(W), .NUM_REQ(N)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_multiplicand (req_multiplicand),
    .req_multiplier   (req_multiplier),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_product      (rsp_product),
    .mul_multiplicand (mul_multiplicand),
    .mul_multiplier   (mul_multiplier),
    .mul_src_valid    (mul_src_valid),
    .mul_src_ready    (mul_src_ready),
    .mul_dest_valid   (mul_dest_valid),
    .mul_dest_ready   (mul_dest_ready),
    .mul_product      (mul_product),
    .busy             (busy),
    .grant_id         (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_ops(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    req_multiplicand[id*W +: W] = a;
    req_multiplier[id*W +: W]   = b;
  endtask

  // One full job for requester id, which must already hold req_valid.
  task automatic serve(input int id, input logic [31:0] exp_prod, input int stall);
    logic signed [31:0] p;
    #1;
    for (int i = 0; i < 20 && req_ready == '0; i++) begin
      @(negedge clk);
      #1;
    end
    chk("grant", 32'(req_ready), 32'(1 << id));
    @(negedge clk);
    req_valid[id] = 1'b0;
    #1;
    chk("issue_busy", 32'(busy), 1);
    chk("issue_id", 32'(grant_id), 32'(id));
    chk("issue_src_valid", 32'(mul_src_valid), 1);
    @(negedge clk);
    chk("src_hold", 32'(mul_src_valid), 1);
    chk("issue_no_ready", 32'(req_ready), 0);
    mul_src_ready = 1'b1;
    @(negedge clk);
    mul_src_ready = 1'b0;
    #1;
    chk("wait_src_drop", 32'(mul_src_valid), 0);
    chk("wait_no_dest_ready", 32'(mul_dest_ready), 0);
    @(negedge clk);
    p = $signed(mul_multiplicand) * $signed(mul_multiplier);
    mul_product    = p;
    mul_dest_valid = 1'b1;
    #1;
    chk("dest_ready", 32'(mul_dest_ready), 1);
    @(negedge clk);
    mul_dest_valid = 1'b0;
    mul_product    = '0;
    #1;
    chk("rsp_valid", 32'(rsp_valid), 32'(1 << id));
    chk("rsp_product", rsp_product, exp_prod);
    rsp_ready = ~(N'(1) << id);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      #1;
      chk("stall_valid", 32'(rsp_valid), 32'(1 << id));
      chk("stall_product", rsp_product, exp_prod);
      chk("stall_no_ready", 32'(req_ready), 0);
    end
    rsp_ready = N'(1) << id;
    @(negedge clk);
    rsp_ready = '0;
    #1;
    chk("done_busy", 32'(busy), 0);
    chk("done_rsp_valid", 32'(rsp_valid), 0);
  endtask

  initial begin
    rst = 1'b0;
    req_valid = 4'b1111;
    req_multiplicand = '0;
    req_multiplier = '0;
    rsp_ready = '0;
    mul_src_ready = 1'b0;
    mul_dest_valid = 1'b0;
    mul_product = '0;
    set_ops(0, 16'd1, 16'd1);
    set_ops(1, 16'd2, 16'd2);
    set_ops(2, 16'd3, 16'd3);
    set_ops(3, -16'sd4, 16'd5);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_product", rsp_product, 0);
    chk("rst_src_valid", 32'(mul_src_valid), 0);
    rst = 1'b1;

    // Round-robin over four competing requesters, requester 0 twice.
    serve(0, 32'd1, 0);
    req_valid[0] = 1'b1;
    serve(1, 32'd4, 0);
    serve(2, 32'd9, 0);
    serve(3, -32'sd20, 0);
    serve(0, 32'd1, 0);

    // Single requester with a mixed-sign pair.
    set_ops(2, 16'd7, -16'sd3);
    req_valid = 4'b0100;
    serve(2, -32'sd21, 0);

    // Most negative operands, response held off for 10 cycles.
    set_ops(1, 16'h8000, 16'h8000);
    req_valid = 4'b0010;
    serve(1, 32'd1073741824, 10);

    // Move last to 3, then 0 must beat 3 after the wrap.
    req_valid = 4'b1000;
    serve(3, -32'sd20, 0);
    req_valid = 4'b1001;
    serve(0, 32'd1, 0);
    serve(3, -32'sd20, 0);

    // Abort a job in WAIT with reset.
    set_ops(2, 16'd9, 16'd9);
    req_valid = 4'b0100;
    @(negedge clk);
    req_valid = '0;
    mul_src_ready = 1'b1;
    @(negedge clk);
    mul_src_ready = 1'b0;
    #1;
    chk("abort_in_wait", 32'(busy), 1);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_rsp_valid", 32'(rsp_valid), 0);
    chk("abort_grant_id", 32'(grant_id), 0);
    chk("abort_product", rsp_product, 0);
    chk("abort_operand", 32'(mul_multiplicand), 0);
    chk("abort_dest_ready", 32'(mul_dest_ready), 0);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("post_abort_rsp", 32'(rsp_valid), 0);
    set_ops(0, 16'd5, 16'd6);
    req_valid = 4'b0001;
    serve(0, 32'd30, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
